// File: rtl/counter_pkg.sv
// Shared types and constants for the JK-based down counter.
// Provides the FSM state enum and the default counter width.
package counter_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/jk_ff_sync.sv
// Single JK flip-flop with synchronous active-low reset.
// Ports: clk, rst (active-low, sync), j, k -> q (hold/reset/set/toggle).
module jk_ff_sync (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_q <= 1'b0;
    end else begin
      unique case ({j, k})
        2'b00: q_q <= q_q;
        2'b01: q_q <= 1'b0;
        2'b10: q_q <= 1'b1;
        2'b11: q_q <= ~q_q;
      endcase
    end
  end

  assign q = q_q;

endmodule

// File: rtl/sync_down_counter_jk.sv
// Down counter built from JK flip-flops with load, auto-reload and one-shot.
// Ports: clk, rst (sync, active-low), en, load, load_val, reload_val,
// oneshot -> q (count), zero (q==0), borrow (underflow pulse), busy (RUN).
module sync_down_counter_jk
  import counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] reload_val,
  input  logic             oneshot,
  output logic [WIDTH-1:0] q,
  output logic             zero,
  output logic             borrow,
  output logic             busy
);

  state_e           state_q;
  logic             borrow_q;
  logic             busy_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] j_d;
  logic [WIDTH-1:0] k_d;
  logic [WIDTH-1:0] tog;
  logic             q_zero;
  logic             run_en;
  logic             dec;
  logic             uflow;
  logic             rel;

  assign q_zero = (cnt_q == '0);
  assign run_en = (state_q == RUN) && en && !load;
  assign dec    = run_en && !q_zero;
  assign uflow  = run_en && q_zero;
  assign rel    = uflow && !oneshot;

  // Bit i of a decrement flips when every lower bit is zero.
  always_comb begin
    tog = '0;
    for (int i = 0; i < WIDTH; i++) begin
      tog[i] = ((cnt_q & ((WIDTH'(1) << i) - WIDTH'(1))) == '0);
    end
  end

  always_comb begin
    j_d = '0;
    k_d = '0;
    unique case (1'b1)
      load: begin
        j_d = load_val;
        k_d = ~load_val;
      end
      dec: begin
        j_d = tog;
        k_d = tog;
      end
      rel: begin
        j_d = reload_val;
        k_d = ~reload_val;
      end
      default: begin
        j_d = '0;
        k_d = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    jk_ff_sync u_ff (
      .clk (clk),
      .rst (rst),
      .j   (j_d[i]),
      .k   (k_d[i]),
      .q   (cnt_q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      borrow_q <= 1'b0;
      if (load) begin
        state_q <= RUN;
        busy_q  <= 1'b1;
      end else if (uflow) begin
        borrow_q <= 1'b1;
        if (oneshot) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
        end
      end
    end
  end

  assign q      = cnt_q;
  assign zero   = q_zero;
  assign borrow = borrow_q;
  assign busy   = busy_q;

endmodule

// File: doc/sync_down_counter_jk.md
SYNC_DOWN_COUNTER_JK -- requirements
Module: sync_down_counter_jk

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter bit width (legal range 2..8).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-004 SHALL have port en, input, 1, count enable (one decrement per enabled cycle).
REQ-005 SHALL have port load, input, 1, synchronous load strobe.
REQ-006 SHALL have port load_val, input, WIDTH, value taken on load.
REQ-007 SHALL have port reload_val, input, WIDTH, value taken on underflow in auto-reload mode.
REQ-008 SHALL have port oneshot, input, 1: 0 = auto-reload, 1 = stop at zero.
REQ-009 SHALL have port q, output, WIDTH, current count (registered).
REQ-010 SHALL have port zero, output, 1, high when q == 0 (combinational from q register).
REQ-011 SHALL have port borrow, output, 1, registered one-cycle pulse on underflow event.
REQ-012 SHALL have port busy, output, 1, high while state is RUN.

Function
REQ-013 SHALL implement FSM with states IDLE, RUN, DONE.
- IDLE: after reset; en ignored; q holds.
- RUN: counting.
- DONE: one-shot expired; en ignored; q holds 0.
REQ-014 SHALL give load priority over en in every state: load=1 -> next q = load_val, next state RUN, borrow = 0.
REQ-015 SHALL, in RUN with en=1, load=0 and q != 0, set next q = q - 1 and borrow = 0.
REQ-016 SHALL, in RUN with en=1, load=0 and q == 0, assert borrow for exactly the next cycle.
- oneshot=0: next q = reload_val; state stays RUN.
- oneshot=1: q stays 0; next state DONE.
REQ-017 SHALL, with en=0 and load=0, hold q and state and drive borrow = 0.
REQ-018 SHALL sample oneshot only on the underflow cycle; a change mid-count takes effect at the next underflow.
REQ-019 SHALL, with reload_val = 0 in auto-reload, hold q at 0 and pulse borrow on every enabled cycle (back-to-back borrow is legal).
REQ-020 SHALL treat load_val = 0 as legal: q = 0, state RUN; the next enabled cycle is an underflow.
REQ-021 SHALL have a latency of one clock from a load or en edge-sample to the q, borrow and busy update.
REQ-022 SHALL derive each counter bit's next state through JK flip-flops.
- Bit i toggles (J=K=1) when the decrement condition holds and all lower bits are 0.
- Load and reload SHALL use J=val[i], K=~val[i].

Reset
REQ-023 SHALL, when rst=0 at a clock edge, set q = 0, borrow = 0 and state = IDLE, so zero = 1 and busy = 0.
REQ-024 SHALL give reset priority over load and en.
REQ-025 SHALL abort any count in progress when reset is asserted mid-operation; no borrow pulse is generated on that edge.
REQ-026 SHALL, on the first edge after release (rst=1), honor load or en normally.

Structure
REQ-027 SHALL place the state enum (IDLE/RUN/DONE) and the default WIDTH constant in shared package counter_pkg.
REQ-028 SHALL use one sub-module, jk_ff_sync: posedge clk, synchronous active-low rst, J/K inputs, q output, with JK truth table hold/reset/set/toggle; it is instantiated WIDTH times.
REQ-029 SHALL keep FSM, borrow register and J/K steering logic in the top module.

Verification
REQ-030 SHALL cover a load and down count: reset, load_val=5, en=1 for 6 cycles -> q 5,4,3,2,1,0; borrow=0 throughout; zero=1 on the last cycle.
REQ-031 SHALL cover auto-reload wrap: q=0, oneshot=0, reload_val=9, en=1 -> q=9, borrow pulses exactly 1 cycle; next cycle q=8, borrow=0.
REQ-032 SHALL cover one-shot expiry: load 2, oneshot=1, en=1 -> q 2,1,0, then borrow pulse, state DONE, busy=0; q stays 0 with en held for 4 more cycles; load 3 -> RUN, q=3.
REQ-033 SHALL cover simultaneous load and en at q=0 with reload_val=7: load_val=4 -> q=4, borrow=0.
REQ-034 SHALL cover reset mid-count: q=6 counting, rst=0 for 1 cycle -> q=0, zero=1, busy=0, borrow=0; en alone afterwards leaves q=0 (IDLE).
REQ-035 SHALL cover degenerate reload: reload_val=0, oneshot=0, q=0, en=1 for 3 cycles -> q=0 and borrow high on all 3 cycles.
